// File: rtl/syn_fifo_pkg.sv
// syn_fifo shared defaults and sizing helper.
// Optional error flags are enabled by defining SYN_FIFO_ERR_EN.
package syn_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// syn_fifo storage: synchronous write port, registered read port.
// The read register clears on reset; the array itself does not.
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-address write and read on a full FIFO returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/syn_fifo.sv
// syn_fifo: single-clock FIFO with count-based full/empty flags.
// Define SYN_FIFO_ERR_EN to add overflow/underflow pulse outputs.
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
`ifdef SYN_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW = ptr_width(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_acc;
  logic          rd_acc;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

  syn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef SYN_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full && !rd_en;
      underflow <= rd_en && empty;
    end
  end
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// Self-checking bench for syn_fifo: vector table, directed corners,
// and a random run against a queue-based reference model.
module tb_syn_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
`ifdef SYN_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  syn_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .full     (full),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef SYN_FIFO_ERR_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] outq[$];
  logic [DW-1:0] inq[$];
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  typedef struct {
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    logic          e_full;
    logic          e_empty;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: occupancy from queue size, pop before push.
  task automatic step(input logic w, input logic r,
                      input logic [DW-1:0] d);
    bit fm, em, ra, wa;
    wr_en = w;
    rd_en = r;
    wr_data = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_data = '0;
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      fm = (q.size() == DEPTH);
      em = (q.size() == 0);
      ra = r && !em;
      wa = w && (!fm || r);
      m_valid = ra;
      if (ra) m_data = q.pop_front();
      if (wa) q.push_back(d);
      m_ovf = w && fm && !r;
      m_unf = r && em;
    end
    #1;
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_valid", 32'(rd_valid), 32'(m_valid));
    chk("m_data", 32'(rd_data), 32'(m_data));
`ifdef SYN_FIFO_ERR_EN
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_unf", 32'(underflow), 32'(m_unf));
`endif
    if (rd_valid) outq.push_back(rd_data);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 8'hA5, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 8'h00, 0, 1, 1, 8'hA5};
    tbl[2]  = '{0, 0, 8'h00, 0, 1, 0, 8'hA5};
    tbl[3]  = '{0, 1, 8'h00, 0, 1, 0, 8'hA5};
    tbl[4]  = '{1, 1, 8'h5A, 0, 0, 0, 8'hA5};
    tbl[5]  = '{0, 1, 8'h00, 0, 1, 1, 8'h5A};
    tbl[6]  = '{1, 0, 8'h11, 0, 0, 0, 8'h5A};
    tbl[7]  = '{1, 0, 8'h22, 0, 0, 0, 8'h5A};
    tbl[8]  = '{1, 1, 8'h33, 0, 0, 1, 8'h11};
    tbl[9]  = '{0, 1, 8'h00, 0, 0, 1, 8'h22};
    tbl[10] = '{0, 1, 8'h00, 0, 1, 1, 8'h33};

    // Reset with requests present on the edge
    rst = 1'b1;
    step(1, 1, 8'h77);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid),
          32'(tbl[i].e_valid));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(tbl[i].e_data));
    end

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i));
    chk("fill_full", 32'(full), 32'd1);
    step(1, 0, 8'hFF);
    chk("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 8'h00);
      chk($sformatf("drain%0d", i), 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(0, 1, 8'h00);
    chk("unf_valid", 32'(rd_valid), 32'd0);
    chk("unf_data", 32'(rd_data), 32'd15);

    // Simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(8'h40 + i));
    step(1, 1, 8'h3C);
    chk("rw_full_data", 32'(rd_data), 32'h40);
    chk("rw_full_flag", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    chk("rw_last", 32'(rd_data), 32'h3C);
    chk("rw_empty", 32'(empty), 32'd1);

    // Mid-operation reset discards stored words
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    rst = 1'b1;
    step(1, 1, 8'h03);
    rst = 1'b0;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_data", 32'(rd_data), 32'd0);
    step(0, 1, 8'h00);
    chk("mid_rst_rd", 32'(rd_valid), 32'd0);

    // Random interleaving across pointer wrap
    outq.delete();
    inq.delete();
    begin
      int cyc = 0;
      while ((inq.size() < 40 || q.size() != 0) && cyc < 2000) begin
        logic w, r;
        logic [DW-1:0] d;
        d = DW'($urandom);
        w = (inq.size() < 40) && ($urandom_range(0, 1) == 1) &&
            (q.size() < DEPTH);
        r = ($urandom_range(0, 2) != 0) || (inq.size() == 40);
        if (w) inq.push_back(d);
        step(w, r, d);
        cyc++;
      end
      chk("rand_timeout", 32'(cyc < 2000), 32'd1);
    end
    chk("rand_count", 32'(outq.size()), 32'(inq.size()));
    for (int i = 0; i < inq.size() && i < outq.size(); i++)
      chk($sformatf("rand%0d", i), 32'(outq[i]), 32'(inq[i]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
